// File: rtl/dynamixel_status_rx.sv
// Dynamixel status-packet receiver: 16x-oversampled UART byte receiver feeding
// a header/field/checksum packet FSM whose captured fields are read by the NIOS front-end.
module dynamixel_status_rx #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 57_600,
    parameter int unsigned MAX_PARAMS  = 4,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic                      MyNios_Clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      RXD,
    output logic                      busy,
    output logic                      rx_valid,
    output logic                      rx_cs_ok,
    output logic                      rx_timeout,
    output logic                      rx_frame_err,
    output logic [7:0]                rx_id,
    output logic [7:0]                rx_len,
    output logic [7:0]                rx_err,
    output logic [8*MAX_PARAMS-1:0]   rx_params
);

    localparam int unsigned OVS_DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned IDX_W   = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;
    localparam int unsigned PW      = 8 * MAX_PARAMS;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HDR1  = 4'd1;
    localparam logic [3:0] S_HDR2  = 4'd2;
    localparam logic [3:0] S_ID    = 4'd3;
    localparam logic [3:0] S_LEN   = 4'd4;
    localparam logic [3:0] S_ERR   = 4'd5;
    localparam logic [3:0] S_PARAM = 4'd6;
    localparam logic [3:0] S_CSUM  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    // RXD synchronizer plus one extra stage for falling-edge detection; idle-high preset
    logic rxd_meta, rxd_sync, rxd_prev;

    always_ff @(posedge MyNios_Clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Byte receiver; bit_cnt 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic             rx_active;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       os_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             byte_done;
    logic             frame_err;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(OVS_DIV - 1));

    always_ff @(posedge MyNios_Clk or posedge reset) begin
        if (reset) begin
            rx_active <= 1'b0;
            div_cnt   <= '0;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            if (!rx_active) begin
                if (rxd_prev && !rxd_sync) begin
                    rx_active <= 1'b1;
                    div_cnt   <= '0;
                    os_cnt    <= '0;
                    bit_cnt   <= '0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    os_cnt <= os_cnt + 4'd1;
                    if (bit_cnt == 4'd0 && os_cnt == 4'd7) begin
                        // mid-start re-sample rejects glitches
                        if (rxd_sync) begin
                            rx_active <= 1'b0;
                        end else begin
                            os_cnt  <= '0;
                            bit_cnt <= 4'd1;
                        end
                    end else if (bit_cnt != 4'd0 && os_cnt == 4'd15) begin
                        if (bit_cnt == 4'd9) begin
                            rx_active <= 1'b0;
                            if (rxd_sync) byte_done <= 1'b1;
                            else          frame_err <= 1'b1;
                        end else begin
                            shift_reg <= {rxd_sync, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Packet FSM state and registered outputs
    logic [3:0]       state, state_d;
    logic             busy_d, valid_d, cs_ok_d, timeout_d, frame_err_d;
    logic [7:0]       id_d, len_d, err_d;
    logic [PW-1:0]    params_d;
    logic [7:0]       sum, sum_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_d;
    logic             tmo_hit;

    always_ff @(posedge MyNios_Clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_cs_ok     <= 1'b0;
            rx_timeout   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_id        <= '0;
            rx_len       <= '0;
            rx_err       <= '0;
            rx_params    <= '0;
            sum          <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_d;
            busy         <= busy_d;
            rx_valid     <= valid_d;
            rx_cs_ok     <= cs_ok_d;
            rx_timeout   <= timeout_d;
            rx_frame_err <= frame_err_d;
            rx_id        <= id_d;
            rx_len       <= len_d;
            rx_err       <= err_d;
            rx_params    <= params_d;
            sum          <= sum_d;
            idx          <= idx_d;
            tmo_cnt      <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state;
        valid_d     = 1'b0;
        cs_ok_d     = rx_cs_ok;
        timeout_d   = rx_timeout;
        frame_err_d = rx_frame_err;
        id_d        = rx_id;
        len_d       = rx_len;
        err_d       = rx_err;
        params_d    = rx_params;
        sum_d       = sum;
        idx_d       = idx;
        tmo_d       = tmo_cnt;

        if (arm) begin
            state_d     = S_HDR1;
            cs_ok_d     = 1'b0;
            timeout_d   = 1'b0;
            frame_err_d = 1'b0;
            id_d        = '0;
            len_d       = '0;
            err_d       = '0;
            params_d    = '0;
            sum_d       = '0;
            idx_d       = '0;
            tmo_d       = '0;
        end else if (state != S_IDLE) begin
            tmo_d = tmo_cnt + 1'b1;
            // a final checksum byte beats a simultaneous timeout
            if (frame_err) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
            end else if (state == S_CSUM && byte_done) begin
                valid_d = 1'b1;
                cs_ok_d = (~sum == shift_reg);
                state_d = S_DONE;
            end else if (state == S_DONE) begin
                state_d = S_IDLE;
            end else if (tmo_hit) begin
                timeout_d = 1'b1;
                state_d   = S_IDLE;
            end else if (byte_done) begin
                case (state)
                    S_HDR1: if (shift_reg == 8'hFF) state_d = S_HDR2;
                    S_HDR2: state_d = (shift_reg == 8'hFF) ? S_ID : S_HDR1;
                    S_ID: begin
                        id_d    = shift_reg;
                        sum_d   = sum + shift_reg;
                        state_d = S_LEN;
                    end
                    S_LEN: begin
                        len_d = shift_reg;
                        sum_d = sum + shift_reg;
                        if (shift_reg < 8'd2 || shift_reg > 8'(MAX_PARAMS + 2)) begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                    S_ERR: begin
                        err_d   = shift_reg;
                        sum_d   = sum + shift_reg;
                        idx_d   = '0;
                        state_d = (rx_len > 8'd2) ? S_PARAM : S_CSUM;
                    end
                    S_PARAM: begin
                        params_d[8*idx +: 8] = shift_reg;
                        sum_d = sum + shift_reg;
                        idx_d = idx + 1'b1;
                        if (8'(idx) == rx_len - 8'd3) state_d = S_CSUM;
                    end
                    default: state_d = state;
                endcase
            end
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_dynamixel_status_rx.sv
// Scoreboard bench for dynamixel_status_rx: serial packets are driven on RXD,
// expected results are queued at stimulus time and compared on each rx_valid pulse.
module tb_dynamixel_status_rx;

    localparam int unsigned CLK_FREQ    = 50_000_000;
    localparam int unsigned BAUD        = 781_250;
    localparam int unsigned MAX_PARAMS  = 4;
    localparam int unsigned TIMEOUT_CYC = 12_000;
    localparam int unsigned BIT_CYC     = 16 * (CLK_FREQ / (BAUD * 16));

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  len;
        logic [7:0]  err;
        logic [31:0] params;
        logic        cs_ok;
    } exp_t;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset, arm, rxd;
    logic        busy, rx_valid, rx_cs_ok, rx_timeout, rx_frame_err;
    logic [7:0]  rx_id, rx_len, rx_err;
    logic [31:0] rx_params;

    exp_t    exp_q[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      valid_cnt = 0;
    int      valid_snap;
    byte_q_t pkt;

    always #5 clk = ~clk;

    dynamixel_status_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_PARAMS(MAX_PARAMS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .MyNios_Clk(clk), .reset(reset), .arm(arm), .RXD(rxd),
        .busy(busy), .rx_valid(rx_valid), .rx_cs_ok(rx_cs_ok), .rx_timeout(rx_timeout),
        .rx_frame_err(rx_frame_err), .rx_id(rx_id), .rx_len(rx_len), .rx_err(rx_err),
        .rx_params(rx_params)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rx_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("id", rx_id, e.id);
                check("len", rx_len, e.len);
                check("err", rx_err, e.err);
                check("params", rx_params, e.params);
                check("cs_ok", rx_cs_ok, e.cs_ok);
            end
        end
    end

    task automatic push_exp(input logic [7:0] id, input logic [7:0] len, input logic [7:0] err,
                            input logic [31:0] params, input logic cs_ok);
        exp_t e;
        e.id = id; e.len = len; e.err = err; e.params = params; e.cs_ok = cs_ok;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rxd = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT_CYC) @(negedge clk);
        rxd = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_pkt(input byte_q_t p);
        foreach (p[i]) send_byte(p[i], 1'b1);
    endtask

    task automatic do_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (40) @(negedge clk);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {busy, rx_valid, rx_cs_ok, rx_timeout, rx_frame_err}, 0);
        check({tag, "_id"}, rx_id, 0);
        check({tag, "_len"}, rx_len, 0);
        check({tag, "_err"}, rx_err, 0);
        check({tag, "_params"}, rx_params, 0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Minimal packet, no parameters
        do_arm();
        check("arm_busy", busy, 1);
        push_exp(8'h01, 8'h02, 8'h00, 32'h0, 1'b1);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_pkt(pkt);
        drain("min");

        // Two parameters
        do_arm();
        push_exp(8'h01, 8'h04, 8'h00, 32'h0000_0120, 1'b1);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD9};
        send_pkt(pkt);
        drain("two");

        // Bad checksum: fields still captured
        do_arm();
        push_exp(8'h01, 8'h04, 8'h00, 32'h0000_0120, 1'b0);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h01, 8'hD8};
        send_pkt(pkt);
        drain("badcs");

        // Maximum parameter count
        do_arm();
        push_exp(8'h02, 8'h06, 8'h00, 32'h4433_2211, 1'b1);
        pkt = '{8'hFF, 8'hFF, 8'h02, 8'h06, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h4D};
        send_pkt(pkt);
        drain("maxp");

        // Header resync after leading garbage
        do_arm();
        push_exp(8'h01, 8'h02, 8'h00, 32'h0, 1'b1);
        pkt = '{8'h00, 8'hFF, 8'h55, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_pkt(pkt);
        drain("resync");

        // LEN one above the legal maximum
        do_arm();
        valid_snap = valid_cnt;
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h07};
        send_pkt(pkt);
        repeat (20) @(negedge clk);
        check("badlen_ferr", rx_frame_err, 1);
        check("badlen_busy", busy, 0);
        check("badlen_novalid", valid_cnt, valid_snap);

        // Stop bit low on the ID byte
        do_arm();
        check("arm_clears_ferr", rx_frame_err, 0);
        valid_snap = valid_cnt;
        pkt = '{8'hFF, 8'hFF};
        send_pkt(pkt);
        send_byte(8'h01, 1'b0);
        repeat (20) @(negedge clk);
        check("stop_ferr", rx_frame_err, 1);
        check("stop_busy", busy, 0);
        check("stop_novalid", valid_cnt, valid_snap);

        // Timeout with an idle line, checked on both sides of the boundary
        do_arm();
        check("arm_clears_ferr2", rx_frame_err, 0);
        valid_snap = valid_cnt;
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        check("tmo_before", rx_timeout, 0);
        check("tmo_busy_before", busy, 1);
        @(negedge clk);
        check("tmo_at", rx_timeout, 1);
        check("tmo_busy_at", busy, 0);
        check("tmo_novalid", valid_cnt, valid_snap);

        // Async reset in the middle of a packet and of a byte
        do_arm();
        valid_snap = valid_cnt;
        pkt = '{8'hFF, 8'hFF, 8'h01};
        send_pkt(pkt);
        fork
            send_byte(8'h02, 1'b1);
            begin
                repeat (300) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check_all_zero("midrst");
            end
        join
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_novalid", valid_cnt, valid_snap);
        check("midrst_busy", busy, 0);

        do_arm();
        push_exp(8'h01, 8'h02, 8'h00, 32'h0, 1'b1);
        pkt = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_pkt(pkt);
        drain("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
